// File: rtl/ldpc_msg_block_loader.sv
// Collects kb Zc-wide message blocks into a register bank and holds them for the encoder core.
// The block arriving this beat is also broadcast with a one-hot bypass select, so it is visible downstream with zero latency.
package LDPC_pkg;
   localparam int MAX_ZC = 384;
endpackage

module ldpc_msg_block_loader
   import LDPC_pkg::*;
#(
   parameter int NUM_BLOCKS = 23,
   parameter int CNT_W      = 5
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic [CNT_W-1:0]                     kb,
   input  logic                                 in_valid,
   input  logic [MAX_ZC-1:0]                    in_block,
   output logic                                 in_ready,
   // "release" is a reserved word, hence the suffix
   input  logic                                 release_i,
   output logic [NUM_BLOCKS-1:0][MAX_ZC-1:0]    stored_msg_blocks,
   output logic [NUM_BLOCKS-1:0][MAX_ZC-1:0]    new_msg_parity_blocks,
   output logic [NUM_BLOCKS-1:0]                select_lines,
   output logic                                 blocks_valid,
   output logic                                 load_err
);

   typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

   state_t                            state_q, state_d;
   logic [CNT_W-1:0]                  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]                  kb_q, kb_d;
   logic                              valid_q, valid_d;
   logic                              err_q, err_d;
   logic [NUM_BLOCKS-1:0][MAX_ZC-1:0] bank_q;

   logic xfer;
   logic kb_legal;
   logic last_beat;

   assign in_ready  = (state_q == LOAD);
   assign xfer      = in_ready & in_valid;
   assign kb_legal  = (kb != '0) && (kb <= CNT_W'(NUM_BLOCKS));
   assign last_beat = (wr_ptr_q == kb_q - CNT_W'(1));

   always_comb begin
      select_lines = '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
         select_lines[i] = xfer && (wr_ptr_q == CNT_W'(i));
      end
   end

   assign new_msg_parity_blocks = {NUM_BLOCKS{in_block}};
   assign stored_msg_blocks     = bank_q;
   assign blocks_valid          = valid_q;
   assign load_err              = err_q;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      kb_d     = kb_q;
      valid_d  = valid_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (kb_legal) begin
                  kb_d     = kb;
                  wr_ptr_d = '0;
                  err_d    = 1'b0;
                  state_d  = LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (xfer) begin
               // Pointer parks on kb-1 after the final beat so it never wraps
               if (last_beat) begin
                  state_d = HOLD;
                  valid_d = 1'b1;
               end else begin
                  wr_ptr_d = wr_ptr_q + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (release_i) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         kb_q     <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         kb_q     <= kb_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q <= '0;
      end else begin
         for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (select_lines[i]) bank_q[i] <= in_block;
         end
      end
   end

endmodule
